issue_pair_sequencer: RTL and testbench
=======================================

ISSUE_PAIR_SEQUENCER -- requirements
Module: issue_pair_sequencer

Interface
REQ-001 Parameter STAGE_WIDTH, default `INSTR_WIDTH (32): width of one decoded instruction word per lane.
REQ-002 Parameter CNT_WIDTH, default 16: width of the split-event performance counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in0, in1  input  STAGE_WIDTH each  older (slot 0) and younger (slot 1) decoded instructions from IF/ID.
REQ-006 valid0, valid1  input  1 each  slot contains a real instruction.
REQ-007 in0_rd[4:0], in0_rd_we  input  5/1  slot-0 destination register and write enable.
REQ-008 in1_rs1[4:0], in1_rs2[4:0], in1_rs1_en, in1_rs2_en  input  5/5/1/1  slot-1 source registers and use flags.
REQ-009 in0_is_mem, in1_is_mem  input  1 each  slot uses the single memory port.
REQ-010 Stall, Flush  input  1 each  pipeline hold and kill from the hazard unit.
REQ-011 ready  output  1  pair accepted this cycle; IF/ID advances only when high.
REQ-012 out0, out1  output  STAGE_WIDTH each  registered instruction issued to lane 0 / lane 1 (ID/EX input).
REQ-013 out0_valid, out1_valid  output  1 each  registered lane-valid flags.
REQ-014 split_active  output  1  high while in SPLIT state.
REQ-015 split_count  output  CNT_WIDTH  saturating count of pairs that were split.

Function
REQ-016 Two states: PAIR (accepting new pairs) and SPLIT (draining a held slot-1 instruction).
REQ-017 conflict = valid0 & valid1 & (RAW | (in0_is_mem & in1_is_mem)).
REQ-018 RAW = in0_rd_we & (in0_rd != 0) & ((in1_rs1_en & in1_rs1 == in0_rd) | (in1_rs2_en & in1_rs2 == in0_rd)).
REQ-019 ready is combinational: ready = (state == PAIR) & ~Stall & ~Flush.
REQ-020 PAIR, ready, no conflict: next cycle out0/out0_valid = in0/valid0 and out1/out1_valid = in1/valid1; state stays PAIR.
REQ-021 PAIR, ready, conflict: next cycle out0 = in0, out0_valid = 1, out1 = 0, out1_valid = 0; in1 captured into hold register; state -> SPLIT; split_count increments unless at all-ones.
REQ-022 SPLIT, ~Stall, ~Flush: next cycle out0 = 0, out0_valid = 0, out1 = hold, out1_valid = 1; hold cleared; state -> PAIR.
REQ-023 valid1 alone (valid0 = 0) issues on lane 1 with no split; valid0 alone issues on lane 0 only.
REQ-024 Issue latency: exactly 1 cycle from acceptance to registered outputs; a split pair occupies 2 consecutive issue cycles with slot 0 always first.
REQ-025 Stall (priority over everything except reset): all registers, state, hold and counter retain values; ready = 0.
REQ-026 Flush with Stall low: outputs, valids and hold cleared to 0, state -> PAIR, no pair accepted that cycle; split_count retained.
REQ-027 Flush while in SPLIT discards the held slot-1 instruction; it is never issued.
REQ-028 split_active = (state == SPLIT), driven from the state register.
REQ-029 Invalid slots (valid low) drive zero on the corresponding out word.

Reset
REQ-030 rst_n low asynchronously forces state = PAIR, out0 = out1 = 0, out0_valid = out1_valid = 0, hold = 0, split_count = 0, split_active = 0.
REQ-031 Reset asserted mid-SPLIT discards the hold register; first post-reset cycle has ready = 1 if Stall and Flush are low.

Verification
REQ-032 Independent pair in0 = 0x00100093, in1 = 0x00200113, both valid -> next cycle both lanes valid with those words, ready stays 1, split_count = 0.
REQ-033 RAW pair in0_rd = 5, in0_rd_we = 1, in1_rs2 = 5, in1_rs2_en = 1 -> cycle 1: lane 0 only, split_active = 1, ready = 0; cycle 2: lane 1 = in1, ready = 1; split_count = 1.
REQ-034 in0_rd = 0 with in1_rs1 = 0 and rs1_en = 1, no memory ops -> no split, both lanes issue together.
REQ-035 Both slots memory ops, Stall held 3 cycles while in SPLIT -> outputs and state frozen 3 cycles, then lane 1 issues the held word.
REQ-036 Flush in SPLIT cycle -> next cycle all outputs 0, state PAIR, held word never appears on out1.
REQ-037 Force split_count to all-ones via repeated conflicting pairs (CNT_WIDTH = 4: 16 splits) -> count stays 0xF; rst_n pulse mid-SPLIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/issue_pair_sequencer_if.sv
// Dual-issue handshake between IF/ID and the pair sequencer feeding ID/EX.
// The slave modport is the sequencer; the master modport is the IF/ID / hazard side.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

interface issue_pair_sequencer_if #(
   parameter int unsigned STAGE_WIDTH = `INSTR_WIDTH,
   parameter int unsigned CNT_WIDTH   = 16
);
   logic [STAGE_WIDTH-1:0] in0;
   logic [STAGE_WIDTH-1:0] in1;
   logic                   valid0;
   logic                   valid1;
   logic [4:0]             in0_rd;
   logic                   in0_rd_we;
   logic [4:0]             in1_rs1;
   logic [4:0]             in1_rs2;
   logic                   in1_rs1_en;
   logic                   in1_rs2_en;
   logic                   in0_is_mem;
   logic                   in1_is_mem;
   logic                   Stall;
   logic                   Flush;
   logic                   ready;
   logic [STAGE_WIDTH-1:0] out0;
   logic [STAGE_WIDTH-1:0] out1;
   logic                   out0_valid;
   logic                   out1_valid;
   logic                   split_active;
   logic [CNT_WIDTH-1:0]   split_count;

   modport slave (
      input  in0, in1, valid0, valid1, in0_rd, in0_rd_we,
             in1_rs1, in1_rs2, in1_rs1_en, in1_rs2_en,
             in0_is_mem, in1_is_mem, Stall, Flush,
      output ready, out0, out1, out0_valid, out1_valid,
             split_active, split_count
   );

   modport master (
      output in0, in1, valid0, valid1, in0_rd, in0_rd_we,
             in1_rs1, in1_rs2, in1_rs1_en, in1_rs2_en,
             in0_is_mem, in1_is_mem, Stall, Flush,
      input  ready, out0, out1, out0_valid, out1_valid,
             split_active, split_count
   );
endinterface

// File: rtl/issue_pair_sequencer.sv
// Dual-issue pair sequencer: issues an IF/ID pair together, or splits it over two
// cycles (slot 0 first) when slot 1 depends on slot 0 or both need the memory port.
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module issue_pair_sequencer #(
   parameter int unsigned STAGE_WIDTH = `INSTR_WIDTH,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   issue_pair_sequencer_if.slave bus
);

   typedef enum logic {
      PAIR  = 1'b0,
      SPLIT = 1'b1
   } state_t;

   state_t                 state;
   logic [STAGE_WIDTH-1:0] out0_q;
   logic [STAGE_WIDTH-1:0] out1_q;
   logic [STAGE_WIDTH-1:0] hold_q;
   logic                   out0_valid_q;
   logic                   out1_valid_q;
   logic [CNT_WIDTH-1:0]   split_cnt_q;

   logic raw_c;
   logic conflict_c;

   // Slot 1 reads a register slot 0 writes (x0 never creates a dependency)
   assign raw_c = bus.in0_rd_we & (bus.in0_rd != 5'd0) &
                  ((bus.in1_rs1_en & (bus.in1_rs1 == bus.in0_rd)) |
                   (bus.in1_rs2_en & (bus.in1_rs2 == bus.in0_rd)));

   assign conflict_c = bus.valid0 & bus.valid1 &
                       (raw_c | (bus.in0_is_mem & bus.in1_is_mem));

   assign bus.ready        = (state == PAIR) & ~bus.Stall & ~bus.Flush;
   assign bus.out0         = out0_q;
   assign bus.out1         = out1_q;
   assign bus.out0_valid   = out0_valid_q;
   assign bus.out1_valid   = out1_valid_q;
   assign bus.split_active = (state == SPLIT);
   assign bus.split_count  = split_cnt_q;

   // Stall freezes everything; Flush kills outputs and any held slot-1 word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= PAIR;
         out0_q       <= '0;
         out1_q       <= '0;
         hold_q       <= '0;
         out0_valid_q <= 1'b0;
         out1_valid_q <= 1'b0;
         split_cnt_q  <= '0;
      end else if (bus.Stall) begin
         state <= state;
      end else if (bus.Flush) begin
         state        <= PAIR;
         out0_q       <= '0;
         out1_q       <= '0;
         hold_q       <= '0;
         out0_valid_q <= 1'b0;
         out1_valid_q <= 1'b0;
      end else begin
         case (state)
            PAIR: begin
               if (conflict_c) begin
                  state        <= SPLIT;
                  out0_q       <= bus.in0;
                  out0_valid_q <= 1'b1;
                  out1_q       <= '0;
                  out1_valid_q <= 1'b0;
                  hold_q       <= bus.in1;
                  if (split_cnt_q != {CNT_WIDTH{1'b1}})
                     split_cnt_q <= split_cnt_q + CNT_WIDTH'(1);
               end else begin
                  state        <= PAIR;
                  out0_q       <= bus.valid0 ? bus.in0 : '0;
                  out0_valid_q <= bus.valid0;
                  out1_q       <= bus.valid1 ? bus.in1 : '0;
                  out1_valid_q <= bus.valid1;
               end
            end
            SPLIT: begin
               state        <= PAIR;
               out0_q       <= '0;
               out0_valid_q <= 1'b0;
               out1_q       <= hold_q;
               out1_valid_q <= 1'b1;
               hold_q       <= '0;
            end
            default: begin
               state <= PAIR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_issue_pair_sequencer.sv
// Directed bench for issue_pair_sequencer: expected lane results are queued as each
// pair is driven and compared after the following rising edge.
module tb_issue_pair_sequencer;

   localparam int unsigned SW = 32;
   localparam int unsigned CW = 4;

   logic clk;
   logic rst_n;

   issue_pair_sequencer_if #(.STAGE_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

   issue_pair_sequencer #(.STAGE_WIDTH(SW), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] o0;
      logic [31:0] o1;
      logic        v0;
      logic        v1;
      logic        sa;
      logic [3:0]  cnt;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   passed = 0;
   int   failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      bus.in0 = '0; bus.in1 = '0; bus.valid0 = 1'b0; bus.valid1 = 1'b0;
      bus.in0_rd = '0; bus.in0_rd_we = 1'b0;
      bus.in1_rs1 = '0; bus.in1_rs2 = '0; bus.in1_rs1_en = 1'b0; bus.in1_rs2_en = 1'b0;
      bus.in0_is_mem = 1'b0; bus.in1_is_mem = 1'b0;
   endtask

   task automatic set_pair(input logic [31:0] a, input logic [31:0] b,
                           input logic v0, input logic v1,
                           input logic [4:0] rd, input logic rd_we,
                           input logic [4:0] rs1, input logic rs1_en,
                           input logic [4:0] rs2, input logic rs2_en,
                           input logic m0, input logic m1);
      bus.in0 = a; bus.in1 = b; bus.valid0 = v0; bus.valid1 = v1;
      bus.in0_rd = rd; bus.in0_rd_we = rd_we;
      bus.in1_rs1 = rs1; bus.in1_rs1_en = rs1_en;
      bus.in1_rs2 = rs2; bus.in1_rs2_en = rs2_en;
      bus.in0_is_mem = m0; bus.in1_is_mem = m1;
   endtask

   task automatic push_exp(input logic [31:0] o0, input logic [31:0] o1,
                           input logic v0, input logic v1, input logic sa,
                           input logic [3:0] cnt);
      exp_t e;
      e.o0 = o0; e.o1 = o1; e.v0 = v0; e.v1 = v1; e.sa = sa; e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic check_ready(input string tag, input logic exp);
      #1;
      check({tag, ".ready"}, 32'(bus.ready), 32'(exp));
   endtask

   task automatic tick(input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         failed++;
         $error("FAIL %s: scoreboard empty, observed out0 0x%08h expected a queued entry", tag, bus.out0);
      end else begin
         e = sb.pop_front();
         check({tag, ".out0"},   bus.out0,                 e.o0);
         check({tag, ".out1"},   bus.out1,                 e.o1);
         check({tag, ".v0"},     32'(bus.out0_valid),      32'(e.v0));
         check({tag, ".v1"},     32'(bus.out1_valid),      32'(e.v1));
         check({tag, ".split"},  32'(bus.split_active),    32'(e.sa));
         check({tag, ".count"},  32'(bus.split_count),     32'(e.cnt));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".out0"},  bus.out0,              32'h0);
      check({tag, ".out1"},  bus.out1,              32'h0);
      check({tag, ".v0"},    32'(bus.out0_valid),   32'h0);
      check({tag, ".v1"},    32'(bus.out1_valid),   32'h0);
      check({tag, ".split"}, 32'(bus.split_active), 32'h0);
      check({tag, ".count"}, 32'(bus.split_count),  32'h0);
   endtask

   logic [3:0]  exp_cnt;
   logic [31:0] wa;
   logic [31:0] wb;

   initial begin
      rst_n = 1'b1;
      bus.Stall = 1'b0;
      bus.Flush = 1'b0;
      idle_in();
      #2 rst_n = 1'b0;
      #1 check_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check_ready("reset_release", 1'b1);

      // independent pair issues together
      set_pair(32'h00100093, 32'h00200113, 1, 1, 5'd1, 1, 5'd0, 1, 5'd0, 0, 0, 0);
      check_ready("indep", 1'b1);
      push_exp(32'h00100093, 32'h00200113, 1, 1, 0, 4'd0);
      tick("indep");

      // RAW via rs2 -> split over two cycles
      set_pair(32'h11111111, 32'h22222222, 1, 1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0);
      check_ready("raw_accept", 1'b1);
      push_exp(32'h11111111, 32'h0, 1, 0, 1, 4'd1);
      tick("raw_c1");
      idle_in();
      check_ready("raw_split", 1'b0);
      push_exp(32'h0, 32'h22222222, 0, 1, 0, 4'd1);
      tick("raw_c2");
      check_ready("raw_done", 1'b1);

      // rd = x0 never creates a dependency
      set_pair(32'h33333333, 32'h44444444, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0);
      push_exp(32'h33333333, 32'h44444444, 1, 1, 0, 4'd1);
      tick("x0_dep");

      // single valid slots; invalid slot word is zeroed
      set_pair(32'hDEAD0000, 32'h55555555, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1);
      push_exp(32'h0, 32'h55555555, 0, 1, 0, 4'd1);
      tick("only_v1");
      set_pair(32'h66666666, 32'hBEEF0000, 1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1);
      push_exp(32'h66666666, 32'h0, 1, 0, 0, 4'd1);
      tick("only_v0");

      // memory-port conflict, then Stall held 3 cycles in SPLIT
      set_pair(32'h77777777, 32'h88888888, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1);
      push_exp(32'h77777777, 32'h0, 1, 0, 1, 4'd2);
      tick("mem_c1");
      idle_in();
      bus.Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_ready("stall", 1'b0);
         push_exp(32'h77777777, 32'h0, 1, 0, 1, 4'd2);
         tick("stall_hold");
      end
      bus.Stall = 1'b0;
      check_ready("stall_release", 1'b0);
      push_exp(32'h0, 32'h88888888, 0, 1, 0, 4'd2);
      tick("mem_c2");

      // Flush in SPLIT discards the held word
      set_pair(32'h99999999, 32'hAAAAAAAA, 1, 1, 5'd7, 1, 5'd7, 1, 5'd0, 0, 0, 0);
      push_exp(32'h99999999, 32'h0, 1, 0, 1, 4'd3);
      tick("flush_c1");
      idle_in();
      bus.Flush = 1'b1;
      check_ready("flush", 1'b0);
      push_exp(32'h0, 32'h0, 0, 0, 0, 4'd3);
      tick("flush_c2");
      bus.Flush = 1'b0;
      check_ready("flush_after", 1'b1);
      push_exp(32'h0, 32'h0, 0, 0, 0, 4'd3);
      tick("flush_gone");

      // Flush in PAIR refuses a valid pair
      set_pair(32'h12345678, 32'h9ABCDEF0, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
      bus.Flush = 1'b1;
      check_ready("flush_pair", 1'b0);
      push_exp(32'h0, 32'h0, 0, 0, 0, 4'd3);
      tick("flush_pair");
      bus.Flush = 1'b0;

      // repeated splits drive the counter into saturation
      exp_cnt = 4'd3;
      for (int i = 0; i < 14; i++) begin
         wa = 32'hA000_0000 + 32'(i);
         wb = 32'hB000_0000 + 32'(i);
         set_pair(wa, wb, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1);
         if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
         push_exp(wa, 32'h0, 1, 0, 1, exp_cnt);
         tick("sat_c1");
         idle_in();
         push_exp(32'h0, wb, 0, 1, 0, exp_cnt);
         tick("sat_c2");
      end
      check("sat_final", 32'(bus.split_count), 32'hF);

      // one more split, then async reset mid-SPLIT
      set_pair(32'hC0C0C0C0, 32'hD0D0D0D0, 1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1);
      push_exp(32'hC0C0C0C0, 32'h0, 1, 0, 1, 4'hF);
      tick("sat_hold");
      idle_in();
      #1 rst_n = 1'b0;
      #1 check_zero("mid_split_reset");
      #1 rst_n = 1'b1;
      check_ready("post_reset", 1'b1);
      push_exp(32'h0, 32'h0, 0, 0, 0, 4'd0);
      tick("post_reset");

      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
